// File: rtl/rsa_pkg.sv
// Shared constants and FSM state type for the RSA exponentiation controller.
package rsa_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;

    // Operand mux select codes
    localparam logic [1:0] SEL_ONE  = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;  // accumulator
    localparam logic [1:0] SEL_B    = 2'b10;  // base
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSqr,
        StSqrWait,
        StMul,
        StMulWait,
        StNext,
        StDone
    } state_e;

endpackage

// File: rtl/rsa_exp_bitcnt.sv
// Loadable down-counter holding the current exponent bit index, with a zero flag.
module rsa_exp_bitcnt #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared multiplier.
// Define RSA_EXP_SKIP_LEADING_ZEROS_EN to skip leading zero exponent bits in INIT.
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] exponent,
    input  logic             mult_done,
    output logic             mult_start,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             acc_init,
    output logic             acc_we,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             first_q, first_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [IDX_W-1:0] idx;
    logic             cur_bit;

    rsa_exp_bitcnt #(
        .CNT_W(IDX_W)
    ) u_bitcnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(TOP_IDX),
        .dec     (cnt_dec),
        .count   (idx),
        .zero    (cnt_zero)
    );

    assign cur_bit = exp_q[idx];

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        first_d    = first_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        mult_start = 1'b0;
        acc_init   = 1'b0;
        acc_we     = 1'b0;
        done       = 1'b0;
        sel_a      = SEL_ZERO;
        sel_b      = SEL_ZERO;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    exp_d    = exponent;
                    cnt_load = 1'b1;
                    first_d  = 1'b1;
                    state_d  = StInit;
                end
            end
            StInit: begin
                // The accumulator is loaded once even if INIT lingers to skip zeros
                acc_init = first_q;
                first_d  = 1'b0;
`ifdef RSA_EXP_SKIP_LEADING_ZEROS_EN
                if (cur_bit) begin
                    state_d = StSqr;
                end else if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
`else
                state_d = StSqr;
`endif
            end
            StSqr: begin
                mult_start = 1'b1;
                sel_a      = SEL_A;
                sel_b      = SEL_A;
                state_d    = StSqrWait;
            end
            StSqrWait: begin
                sel_a  = SEL_A;
                sel_b  = SEL_A;
                acc_we = mult_done;
                if (mult_done) begin
                    state_d = cur_bit ? StMul : StNext;
                end
            end
            StMul: begin
                mult_start = 1'b1;
                sel_a      = SEL_A;
                sel_b      = SEL_B;
                state_d    = StMulWait;
            end
            StMulWait: begin
                sel_a  = SEL_A;
                sel_b  = SEL_B;
                acc_we = mult_done;
                if (mult_done) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                    state_d = StSqr;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle) && (state_q != StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            exp_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            first_q <= first_d;
        end
    end

endmodule

// File: doc/rsa_exp_ctrl.md
RSA_EXP_CTRL -- requirements
Module: rsa_exp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning the exponent bit width; it matches the operand mux width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request one exponentiation; sampled only in IDLE.
REQ-005 SHALL have port exponent, input, WIDTH bits: exponent value; captured on accepted start.
REQ-006 SHALL have port mult_done, input, 1 bit: one-cycle completion pulse from the shared multiplier.
REQ-007 SHALL have port mult_start, output, 1 bit: one-cycle pulse that launches the multiplier.
REQ-008 SHALL have port sel_a, output, 2 bits: select code for operand mux A.
REQ-009 SHALL have port sel_b, output, 2 bits: select code for operand mux B.
REQ-010 SHALL have port acc_init, output, 1 bit: one-cycle pulse that loads the accumulator with one.
REQ-011 SHALL have port acc_we, output, 1 bit: accumulator write enable for the multiplier result.
REQ-012 SHALL have ports busy (level) and done (one-cycle pulse), output, 1 bit each.

Function
REQ-013 SHALL encode mux selects as: 00 = constant one, 01 = accumulator, 10 = base, 11 = zero.
REQ-014 SHALL implement the FSM states IDLE, INIT, SQR, SQR_WAIT, MUL, MUL_WAIT, NEXT and DONE.
REQ-015 SHALL, in IDLE with start=1, capture exponent, set bit index to WIDTH-1, and go to INIT; busy rises the next cycle.
REQ-016 SHALL, in INIT, pulse acc_init for one cycle, then go to SQR.
REQ-017 SHALL, in SQR, pulse mult_start with sel_a=01 and sel_b=01, then go to SQR_WAIT.
REQ-018 SHALL, in MUL, pulse mult_start with sel_a=01 and sel_b=10, then go to MUL_WAIT.
REQ-019 SHALL hold sel_a and sel_b stable from the mult_start cycle through the mult_done cycle.
REQ-020 SHALL, in both WAIT states, remain until mult_done=1; acc_we = mult_done in that same cycle (combinational).
REQ-021 SHALL, on exit from SQR_WAIT, go to MUL if the current exponent bit is 1, else go to NEXT.
REQ-022 SHALL, on exit from MUL_WAIT, go to NEXT.
REQ-023 SHALL, in NEXT, go to DONE if the bit index is 0; otherwise decrement the index and go to SQR.
REQ-024 SHALL, in DONE, pulse done for one cycle, deassert busy, and return to IDLE.
REQ-025 SHALL drive sel_a=11 and sel_b=11 in every state outside the SQR/MUL-to-WAIT windows.
REQ-026 SHALL ignore start while busy; the captured exponent SHALL NOT change mid-operation.
REQ-027 SHALL ignore mult_done outside the WAIT states: no acc_we and no state change.
REQ-028 SHALL handle exponent 0 (without the macro) as WIDTH squares, 0 multiplies, then done.

Reset
REQ-029 SHALL, on rst, immediately force state IDLE, bit index 0 and captured exponent 0.
REQ-030 SHALL, on rst, drive mult_start, acc_init, acc_we, busy and done to 0, and sel_a and sel_b to 11.
REQ-031 SHALL treat rst mid-operation as an abort: no done pulse, and a late mult_done after reset is ignored.

Configuration
REQ-032 SHALL, with RSA_EXP_SKIP_LEADING_ZEROS_EN defined, skip leading zero exponent bits.
- INIT decrements the index past leading zeros at 1 bit/cycle before entering SQR.
- An exponent of 0 goes INIT -> DONE with no multiplier operations.
REQ-033 SHALL, without RSA_EXP_SKIP_LEADING_ZEROS_EN, process all WIDTH bits.

Structure
REQ-034 SHALL place the select-code constants (SEL_ONE, SEL_A, SEL_B, SEL_ZERO), the FSM state typedef and the default WIDTH in the shared package rsa_pkg.
REQ-035 SHALL use one sub-module, rsa_exp_bitcnt: the loadable down-counter holding the bit index, with a zero flag.

Verification
REQ-036 SHALL verify: exponent=10'b0000000101, multiplier stub done after 2 cycles, macro off -> 10 squares and 2 multiplies (after bits 2 and 0), 12 acc_we, 1 done.
REQ-037 SHALL verify: the same stimulus with the macro on -> 3 squares and 2 multiplies, 5 acc_we.
REQ-038 SHALL verify: exponent=0 -> macro off: 10 squares and done; macro on: acc_init then done within 12 cycles, no mult_start.
REQ-039 SHALL verify: start pulsed during SQR_WAIT with a different exponent -> ignored; the operation count is unchanged.
REQ-040 SHALL verify: rst asserted in MUL_WAIT, then a stray mult_done -> all outputs at reset values, no acc_we, no done; a new start runs correctly.
REQ-041 SHALL verify: mult_done delay randomized from 1 to 20 cycles -> sel_a/sel_b stable across every WAIT window, each mult_start matched by exactly one acc_we.
